// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  // Controller state: normal flow, or holding the front end while a
  // multi-cycle EX operation completes.
  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } state_t;

  // Default register index width of the core.
  localparam int REG_W = 5;

  // Index of the hard-wired zero register; writes to it never create a hazard.
  localparam int unsigned X0_IDX = 0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// There is no valid/ready handshake on this bundle: every signal is a level
// sampled each cycle. Hazard inputs flow datapath -> controller, and the
// stage enables/flushes plus the perf counters flow controller -> datapath.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
);
  import pipe_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [REG_W-1:0] ex_rd;
  logic             ex_mem_read;
  logic             ex_mispredict;
  logic             mc_start;
  logic             mc_done;
  logic             dmem_stall;

  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             if_flush_mark;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             ex_mem_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Current controller state, exported for observation.
  state_t           dbg_state;

  // Datapath side: reports hazards, consumes enables.
  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
           ex_mispredict, mc_start, mc_done, dmem_stall,
    input  pc_en, if_id_en, if_id_flush, if_flush_mark, id_ex_en, id_ex_flush,
           ex_mem_en, ex_mem_flush, stall_cnt, flush_cnt, dbg_state
  );

  // Controller side.
  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
           ex_mispredict, mc_start, mc_done, dmem_stall,
    output pc_en, if_id_en, if_id_flush, if_flush_mark, id_ex_en, id_ex_flush,
           ex_mem_en, ex_mem_flush, stall_cnt, flush_cnt, dbg_state
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the performance counters.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, otherwise step unless already at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipe. Stage controls are
// combinational from state and hazard inputs; priority is
// dmem freeze > redirect > multi-cycle wait > load-use > normal flow.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W        = pipe_ctrl_pkg::REG_W,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  // Width that holds FLUSH_CYCLES-1; at least one bit so FLUSH_CYCLES=1 works.
  localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_t          state_q, state_d;
  logic [FL_W-1:0] flush_left_q, flush_left_d;
  logic            redirect_pend_q, redirect_pend_d;

  logic pc_en, if_id_en, if_id_flush, if_flush_mark;
  logic id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush;
  logic flush_inc;
  logic load_use;
  logic redirect;

  // A load in EX whose destination feeds the instruction in ID.
  always_comb begin
    load_use = bus.ex_mem_read && (bus.ex_rd != REG_W'(X0_IDX)) &&
               ((bus.id_rs1_used && (bus.id_rs1 == bus.ex_rd)) ||
                (bus.id_rs2_used && (bus.id_rs2 == bus.ex_rd)));
  end

  assign redirect = bus.ex_mispredict || redirect_pend_q;

  // Priority mux for stage controls plus next-state for the FSM and counters.
  always_comb begin
    pc_en           = 1'b0;
    if_id_en        = 1'b0;
    if_id_flush     = 1'b0;
    if_flush_mark   = 1'b0;
    id_ex_en        = 1'b0;
    id_ex_flush     = 1'b0;
    ex_mem_en       = 1'b0;
    ex_mem_flush    = 1'b0;
    flush_inc       = 1'b0;
    state_d         = state_q;
    flush_left_d    = flush_left_q;
    redirect_pend_d = redirect_pend_q;

    if (rst) begin
      // Everything held quiet while reset is asserted.
    end else if (bus.dmem_stall) begin
      // Global freeze; a mispredict seen now is remembered and applied later.
      if (bus.ex_mispredict) begin
        redirect_pend_d = 1'b1;
      end
    end else if (redirect) begin
      // Redirect squashes IF/ID and ID/EX; the branch itself retires into MEM.
      // Any pending multi-cycle op is younger than the branch and is abandoned.
      pc_en           = 1'b1;
      if_id_flush     = 1'b1;
      if_flush_mark   = 1'b1;
      id_ex_flush     = 1'b1;
      ex_mem_en       = 1'b1;
      redirect_pend_d = 1'b0;
      flush_left_d    = FL_W'(FLUSH_CYCLES - 1);
      flush_inc       = 1'b1;
      state_d         = RUN;
    end else if (state_q == MC_WAIT) begin
      // Front end held; MEM sees bubbles until the result is ready, then the
      // op moves into MEM and ID/EX takes a bubble behind it.
      ex_mem_en = 1'b1;
      if (bus.mc_done) begin
        id_ex_flush = 1'b1;
        state_d     = RUN;
      end else begin
        ex_mem_flush = 1'b1;
      end
    end else begin
      if (load_use) begin
        // Hold PC and IF/ID for one cycle, write a bubble into ID/EX.
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
      end else begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        // Stale fetches after a redirect are marked until the count drains.
        if (flush_left_q != '0) begin
          if_flush_mark = 1'b1;
          flush_left_d  = flush_left_q - 1'b1;
        end
      end
      // A multi-cycle op finishing in its launch cycle needs no wait.
      if (bus.mc_start && !bus.mc_done) begin
        state_d = MC_WAIT;
      end
    end
  end

  // State, redirect bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= RUN;
      flush_left_q    <= '0;
      redirect_pend_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      flush_left_q    <= flush_left_d;
      redirect_pend_q <= redirect_pend_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (!pc_en),
    .clr (1'b0),
    .cnt (bus.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .clr (1'b0),
    .cnt (bus.flush_cnt)
  );

  assign bus.pc_en         = pc_en;
  assign bus.if_id_en      = if_id_en;
  assign bus.if_id_flush   = if_id_flush;
  assign bus.if_flush_mark = if_flush_mark;
  assign bus.id_ex_en      = id_ex_en;
  assign bus.id_ex_flush   = id_ex_flush;
  assign bus.ex_mem_en     = ex_mem_en;
  assign bus.ex_mem_flush  = ex_mem_flush;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl. Stage controls are packed as
// {pc_en, if_id_en, if_id_flush, if_flush_mark, id_ex_en, id_ex_flush,
//  ex_mem_en, ex_mem_flush} and compared against hand-computed vectors.
module tb_pipeline_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam logic [7:0] V_OFF   = 8'b0000_0000;
  localparam logic [7:0] V_NORM  = 8'b1100_1010;
  localparam logic [7:0] V_NMARK = 8'b1101_1010;
  localparam logic [7:0] V_LU    = 8'b0000_1110;
  localparam logic [7:0] V_REDIR = 8'b1011_0110;
  localparam logic [7:0] V_MCW   = 8'b0000_0011;
  localparam logic [7:0] V_MCDN  = 8'b0000_0110;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(32)) bus ();
  pipeline_hazard_ctrl_if #(.REG_W(5), .CNT_W(4))  sbus ();

  pipeline_hazard_ctrl #(.REG_W(5), .FLUSH_CYCLES(2), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pipeline_hazard_ctrl #(.REG_W(5), .FLUSH_CYCLES(2), .CNT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  logic [7:0] ctrl_vec;
  assign ctrl_vec = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.if_flush_mark,
                     bus.id_ex_en, bus.id_ex_flush, bus.ex_mem_en, bus.ex_mem_flush};

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.id_rs1 = '0;  bus.id_rs2 = '0;  bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0;
    bus.ex_rd  = '0;  bus.ex_mem_read = 1'b0; bus.ex_mispredict = 1'b0;
    bus.mc_start = 1'b0; bus.mc_done = 1'b0; bus.dmem_stall = 1'b0;
  endtask

  // Compare the controls against the next expected vector mid-cycle, then
  // advance to just after the following rising edge.
  task automatic run_cycle(input string tag);
    logic [7:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: got 0x%0h expected <empty queue>", tag, ctrl_vec);
    end else begin
      e = exp_q.pop_front();
      check(tag, {24'd0, ctrl_vec}, {24'd0, e});
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    sbus.id_rs1 = '0;  sbus.id_rs2 = '0;  sbus.id_rs1_used = 1'b0; sbus.id_rs2_used = 1'b0;
    sbus.ex_rd  = '0;  sbus.ex_mem_read = 1'b0; sbus.ex_mispredict = 1'b0;
    sbus.mc_start = 1'b0; sbus.mc_done = 1'b0; sbus.dmem_stall = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {24'd0, ctrl_vec}, 32'd0);
    check("rst_state", {31'd0, bus.dbg_state}, {31'd0, RUN});
    check("rst_stall_cnt", bus.stall_cnt, 32'd0);
    check("rst_flush_cnt", bus.flush_cnt, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    exp_q.push_back(V_NORM);
    run_cycle("idle_norm");

    // Load-use on rs1: one stall cycle with a bubble into ID/EX.
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_rs1_used = 1'b1;
    exp_q.push_back(V_LU);
    run_cycle("lu_rs1");
    idle();
    exp_q.push_back(V_NORM);
    run_cycle("lu_rs1_release");
    check("lu_stall_cnt", bus.stall_cnt, 32'd1);

    // Load-use on rs2.
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd7; bus.id_rs2 = 5'd7; bus.id_rs2_used = 1'b1;
    bus.id_rs1 = 5'd3; bus.id_rs1_used = 1'b1;
    exp_q.push_back(V_LU);
    run_cycle("lu_rs2");
    idle();

    // Non-hazards: x0 destination, unused rs2, non-load in EX.
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_rs1_used = 1'b1;
    exp_q.push_back(V_NORM);
    run_cycle("no_lu_x0");
    bus.ex_rd = 5'd9; bus.id_rs1 = 5'd1; bus.id_rs2 = 5'd9; bus.id_rs2_used = 1'b0;
    exp_q.push_back(V_NORM);
    run_cycle("no_lu_rs2_unused");
    bus.ex_mem_read = 1'b0; bus.id_rs2_used = 1'b1;
    exp_q.push_back(V_NORM);
    run_cycle("no_lu_not_load");
    idle();
    check("no_lu_stall_cnt", bus.stall_cnt, 32'd2);

    // Mispredict: flush for one cycle, mark for two enabled cycles.
    bus.ex_mispredict = 1'b1;
    exp_q.push_back(V_REDIR);
    run_cycle("redir");
    idle();
    exp_q.push_back(V_NMARK);
    exp_q.push_back(V_NORM);
    run_cycle("redir_mark2");
    run_cycle("redir_done");
    check("redir_flush_cnt", bus.flush_cnt, 32'd1);

    // Multi-cycle op, done four cycles after launch.
    bus.mc_start = 1'b1;
    exp_q.push_back(V_NORM);
    run_cycle("mc_launch");
    bus.mc_start = 1'b0;
    check("mc_state_wait", {31'd0, bus.dbg_state}, {31'd0, MC_WAIT});
    exp_q.push_back(V_MCW);
    exp_q.push_back(V_MCW);
    exp_q.push_back(V_MCW);
    run_cycle("mc_wait1");
    run_cycle("mc_wait2");
    run_cycle("mc_wait3");
    bus.mc_done = 1'b1;
    exp_q.push_back(V_MCDN);
    run_cycle("mc_done");
    bus.mc_done = 1'b0;
    check("mc_state_run", {31'd0, bus.dbg_state}, {31'd0, RUN});
    exp_q.push_back(V_NORM);
    run_cycle("mc_after");
    check("mc_stall_cnt", bus.stall_cnt, 32'd6);

    // Single-cycle op: start and done together never stalls.
    bus.mc_start = 1'b1; bus.mc_done = 1'b1;
    exp_q.push_back(V_NORM);
    run_cycle("mc_1cyc");
    idle();
    exp_q.push_back(V_NORM);
    run_cycle("mc_1cyc_after");
    check("mc_1cyc_stall_cnt", bus.stall_cnt, 32'd6);

    // Data-memory freeze with a mispredict arriving in its second cycle.
    bus.dmem_stall = 1'b1;
    exp_q.push_back(V_OFF);
    run_cycle("freeze1");
    bus.ex_mispredict = 1'b1;
    exp_q.push_back(V_OFF);
    run_cycle("freeze2_mispredict");
    bus.ex_mispredict = 1'b0;
    exp_q.push_back(V_OFF);
    run_cycle("freeze3");
    idle();
    exp_q.push_back(V_REDIR);
    exp_q.push_back(V_NMARK);
    exp_q.push_back(V_NORM);
    run_cycle("freeze_redir");
    run_cycle("freeze_mark");
    run_cycle("freeze_done");
    check("freeze_flush_cnt", bus.flush_cnt, 32'd2);
    check("freeze_stall_cnt", bus.stall_cnt, 32'd9);

    // Redirect aborts a multi-cycle wait.
    bus.mc_start = 1'b1;
    exp_q.push_back(V_NORM);
    run_cycle("abort_launch");
    bus.mc_start = 1'b0;
    exp_q.push_back(V_MCW);
    run_cycle("abort_wait");
    bus.ex_mispredict = 1'b1;
    exp_q.push_back(V_REDIR);
    run_cycle("abort_redir");
    idle();
    check("abort_state", {31'd0, bus.dbg_state}, {31'd0, RUN});
    exp_q.push_back(V_NMARK);
    run_cycle("abort_mark");
    check("abort_flush_cnt", bus.flush_cnt, 32'd3);
    check("abort_stall_cnt", bus.stall_cnt, 32'd10);

    // Asynchronous reset in the middle of a multi-cycle wait.
    bus.mc_start = 1'b1;
    exp_q.push_back(V_NORM);
    run_cycle("rst_mc_launch");
    bus.mc_start = 1'b0;
    #2;
    check("rst_mc_pre_state", {31'd0, bus.dbg_state}, {31'd0, MC_WAIT});
    rst = 1'b1;
    #1;
    check("rst_mc_ctrl", {24'd0, ctrl_vec}, 32'd0);
    check("rst_mc_state", {31'd0, bus.dbg_state}, {31'd0, RUN});
    check("rst_mc_stall_cnt", bus.stall_cnt, 32'd0);
    check("rst_mc_flush_cnt", bus.flush_cnt, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(V_NORM);
    run_cycle("rst_mc_after");

    // Saturation on the 4-bit instance: 20 frozen cycles.
    sbus.dmem_stall = 1'b1;
    #2;
    check("sat_pc_en", {31'd0, sbus.pc_en}, 32'd0);
    repeat (14) @(posedge clk);
    #1;
    check("sat_cnt14", {28'd0, sbus.stall_cnt}, 32'd14);
    repeat (6) @(posedge clk);
    #1;
    check("sat_cnt20", {28'd0, sbus.stall_cnt}, 32'd15);
    check("sat_flush_cnt", {28'd0, sbus.flush_cnt}, 32'd0);
    sbus.dmem_stall = 1'b0;

    // ---------------- final report ----------------
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL exp_q_drain: got %0d left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
